// File: rtl/icache_plru_pkg.sv
// icache_plru_pkg: shared types and constants for the I-Cache PLRU replacement unit.
//   way_t      - 2-bit way index
//   plru_t     - 3 PLRU bits per set: [0]=b0 root, [1]=b1 (w0/w1), [2]=b2 (w2/w3)
//   NUM_WAYS   - cache associativity
//   i_state_e  - per-way valid-bit encoding shared with the hit/miss checker
package icache_plru_pkg;

    localparam int unsigned NUM_WAYS  = 4;
    localparam int unsigned WAY_WIDTH = 2;
    localparam int unsigned PLRU_BITS = 3;

    typedef logic [WAY_WIDTH-1:0] way_t;
    typedef logic [PLRU_BITS-1:0] plru_t;

    typedef enum logic {
        I_ST_INVALID = 1'b0,
        I_ST_VALID   = 1'b1
    } i_state_e;

endpackage

// File: rtl/icache_plru_if.sv
// icache_plru_if: lookup/update/result bundle between the cache controller and icache_plru.
//   master: controller side (drives lookup, checker results, update, flush)
//   slave : icache_plru side (returns sel_valid/sel_way/sel_hit)
// With ICACHE_PLRU_STATS_EN defined the bundle also carries stat_clear, hit_count, miss_count.
interface icache_plru_if
    import icache_plru_pkg::*;
#(
    parameter int unsigned INDEX_WIDTH = 6
`ifdef ICACHE_PLRU_STATS_EN
    , parameter int unsigned STAT_WIDTH = 32
`endif
) ();

    logic                   lookup_en;
    logic [INDEX_WIDTH-1:0] lookup_index;
    logic                   hit;
    way_t                   hit_way;
    logic                   full;
    logic [NUM_WAYS-1:0]    valid;
    logic                   update_en;
    logic [INDEX_WIDTH-1:0] update_index;
    way_t                   update_way;
    logic                   flush;
    logic                   sel_valid;
    way_t                   sel_way;
    logic                   sel_hit;
`ifdef ICACHE_PLRU_STATS_EN
    logic                   stat_clear;
    logic [STAT_WIDTH-1:0]  hit_count;
    logic [STAT_WIDTH-1:0]  miss_count;
`endif

    modport master (
        output lookup_en, lookup_index, hit, hit_way, full, valid,
        output update_en, update_index, update_way, flush,
`ifdef ICACHE_PLRU_STATS_EN
        output stat_clear,
        input  hit_count, miss_count,
`endif
        input  sel_valid, sel_way, sel_hit
    );

    modport slave (
        input  lookup_en, lookup_index, hit, hit_way, full, valid,
        input  update_en, update_index, update_way, flush,
`ifdef ICACHE_PLRU_STATS_EN
        input  stat_clear,
        output hit_count, miss_count,
`endif
        output sel_valid, sel_way, sel_hit
    );

endinterface

// File: rtl/icache_plru_plru_tree4.sv
// plru_tree4: combinational 4-way tree-PLRU helpers.
//   i_update_bits/i_update_way -> o_next_bits_c : bits after touching i_update_way
//   i_lookup_bits, i_fwd       -> o_victim_c    : victim from lookup bits, or from
//                                                 o_next_bits_c when i_fwd is set
module plru_tree4
    import icache_plru_pkg::*;
(
    input  plru_t i_lookup_bits,
    input  plru_t i_update_bits,
    input  way_t  i_update_way,
    input  logic  i_fwd,
    output plru_t o_next_bits_c,
    output way_t  o_victim_c
);

    plru_t w_src;

    // Touching a way points the bits on its path away from it; other bits hold.
    always_comb begin
        o_next_bits_c = i_update_bits;
        unique case (i_update_way)
            2'd0:    begin o_next_bits_c[0] = 1'b1; o_next_bits_c[1] = 1'b1; end
            2'd1:    begin o_next_bits_c[0] = 1'b1; o_next_bits_c[1] = 1'b0; end
            2'd2:    begin o_next_bits_c[0] = 1'b0; o_next_bits_c[2] = 1'b1; end
            default: begin o_next_bits_c[0] = 1'b0; o_next_bits_c[2] = 1'b0; end
        endcase
    end

    // Follow the tree: 0 points to the lower side at each level.
    always_comb begin
        w_src = i_fwd ? o_next_bits_c : i_lookup_bits;
        if (w_src[0] == 1'b0) begin
            o_victim_c = w_src[1] ? 2'd1 : 2'd0;
        end else begin
            o_victim_c = w_src[2] ? 2'd3 : 2'd2;
        end
    end

endmodule

// File: rtl/icache_plru.sv
// icache_plru: tree pseudo-LRU replacement unit for the 4-way I-Cache.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : icache_plru_if.slave (lookup request + checker results, access
//                update, flush; registered sel_valid/sel_way/sel_hit result)
// Optional macro ICACHE_PLRU_STATS_EN adds saturating hit/miss counters with
// synchronous stat_clear on the interface.
module icache_plru
    import icache_plru_pkg::*;
#(
    parameter int unsigned INDEX_WIDTH = 6
`ifdef ICACHE_PLRU_STATS_EN
    , parameter int unsigned STAT_WIDTH = 32
`endif
) (
    input  logic          clk,
    input  logic          reset,
    icache_plru_if.slave  bus
);

    localparam int unsigned NUM_SETS = 2 ** INDEX_WIDTH;

    // Flop array: flush clears every set in one cycle and reset is asynchronous.
    plru_t r_plru [NUM_SETS];

    logic  r_sel_valid;
    way_t  r_sel_way;
    logic  r_sel_hit;

    plru_t w_next_bits;
    way_t  w_victim;
    way_t  w_free_way;
    way_t  w_sel_way;
    logic  w_fwd;

    // Same-cycle update to the looked-up set is forwarded into the victim choice.
    assign w_fwd = bus.update_en && bus.lookup_en && (bus.lookup_index == bus.update_index);

    plru_tree4 u_tree (
        .i_lookup_bits (r_plru[bus.lookup_index]),
        .i_update_bits (r_plru[bus.update_index]),
        .i_update_way  (bus.update_way),
        .i_fwd         (w_fwd),
        .o_next_bits_c (w_next_bits),
        .o_victim_c    (w_victim)
    );

    // Lowest-index invalid way; scanning downward lets the lowest index win.
    always_comb begin
        w_free_way = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (bus.valid[i] == I_ST_INVALID) begin
                w_free_way = WAY_WIDTH'(i);
            end
        end
    end

    always_comb begin
        w_sel_way = w_victim;
        if (bus.hit) begin
            w_sel_way = bus.hit_way;
        end else if (!bus.full) begin
            w_sel_way = w_free_way;
        end
    end

    // PLRU state; flush beats a coincident update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < NUM_SETS; s++) r_plru[s] <= '0;
        end else if (bus.flush) begin
            for (int s = 0; s < NUM_SETS; s++) r_plru[s] <= '0;
        end else if (bus.update_en) begin
            r_plru[bus.update_index] <= w_next_bits;
        end
    end

    // Registered selection result; way/hit hold until the next lookup.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sel_valid <= 1'b0;
            r_sel_way   <= '0;
            r_sel_hit   <= 1'b0;
        end else begin
            r_sel_valid <= bus.lookup_en;
            if (bus.lookup_en) begin
                r_sel_way <= w_sel_way;
                r_sel_hit <= bus.hit;
            end
        end
    end

    assign bus.sel_valid = r_sel_valid;
    assign bus.sel_way   = r_sel_way;
    assign bus.sel_hit   = r_sel_hit;

`ifdef ICACHE_PLRU_STATS_EN
    logic [STAT_WIDTH-1:0] r_hit_count;
    logic [STAT_WIDTH-1:0] r_miss_count;

    // Saturating lookup counters; clear beats increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else if (bus.stat_clear) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else if (bus.lookup_en) begin
            if (bus.hit && (r_hit_count != '1)) begin
                r_hit_count <= r_hit_count + 1'b1;
            end
            if (!bus.hit && (r_miss_count != '1)) begin
                r_miss_count <= r_miss_count + 1'b1;
            end
        end
    end

    assign bus.hit_count  = r_hit_count;
    assign bus.miss_count = r_miss_count;
`endif

endmodule
